// File: rtl/kl_pipe_pkg.sv
// Shared widths and the write-history entry type for the writeback/forwarding path.
package kl_pipe_pkg;

    localparam int DATA_W    = 16;
    localparam int REGNUM_W  = 3;
    localparam int NUM_REGS  = 2 ** REGNUM_W;
    localparam int FWD_DEPTH = 6;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic [REGNUM_W-1:0] num;
        logic                wr;
    } wb_entry_t;

endpackage

// File: rtl/kl_regfile.sv
// Architectural register file: async reads, one sync write, sync reset to 0.
// Write lands at the edge; reads see it the following cycle. No backpressure.
module kl_regfile
    import kl_pipe_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [REGNUM_W-1:0] wr_num,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [REGNUM_W-1:0] rd_a_num,
    output logic [DATA_W-1:0]   rd_a_data,
    input  logic [REGNUM_W-1:0] rd_b_num,
    output logic [DATA_W-1:0]   rd_b_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_num] <= wr_data;
        end
    end

    assign rd_a_data = regs[rd_a_num];
    assign rd_b_data = regs[rd_b_num];

endmodule

// File: rtl/wb_history_pipe.sv
// Last six register writes (m1 newest) feeding forwarding; oldest retires into the regfile.
// Result visible on m1 one edge after capture, in regfile after the 6th advance; stall_in freezes everything.
module wb_history_pipe
    import kl_pipe_pkg::*;
#(
    parameter int DEPTH       = FWD_DEPTH,
    parameter int FLUSH_SLOTS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_in,
    input  logic                flush_in,
    input  logic                res_valid_in,
    input  logic                res_write_in,
    input  logic [REGNUM_W-1:0] res_num_in,
    input  logic [DATA_W-1:0]   res_data_in,
    input  logic [REGNUM_W-1:0] rd_a_num_in,
    input  logic [REGNUM_W-1:0] rd_b_num_in,
    output logic [DATA_W-1:0]   rd_a_data_out,
    output logic [DATA_W-1:0]   rd_b_data_out,
    output logic [DATA_W-1:0]   data_m1_out,
    output logic [DATA_W-1:0]   data_m2_out,
    output logic [DATA_W-1:0]   data_m3_out,
    output logic [DATA_W-1:0]   data_m4_out,
    output logic [DATA_W-1:0]   data_m5_out,
    output logic [DATA_W-1:0]   data_m6_out,
    output logic [REGNUM_W-1:0] num_m1_out,
    output logic [REGNUM_W-1:0] num_m2_out,
    output logic [REGNUM_W-1:0] num_m3_out,
    output logic [REGNUM_W-1:0] num_m4_out,
    output logic [REGNUM_W-1:0] num_m5_out,
    output logic [REGNUM_W-1:0] num_m6_out,
    output logic                m1_write_out,
    output logic                m2_write_out,
    output logic                m3_write_out,
    output logic                m4_write_out,
    output logic                m5_write_out,
    output logic                m6_write_out,
    output logic [15:0]         retire_count_out
);

    wb_entry_t hist [1:DEPTH];
    logic      retire_wr;

    // A flush reaching as deep as the oldest slot also kills its retirement.
    assign retire_wr = ~stall_in & hist[DEPTH].wr & ~(flush_in && FLUSH_SLOTS >= DEPTH);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= DEPTH; k++) hist[k] <= '0;
            retire_count_out <= '0;
        end else if (stall_in) begin
            if (flush_in) begin
                for (int k = 1; k <= FLUSH_SLOTS; k++) hist[k].wr <= 1'b0;
            end
        end else begin
            hist[1] <= '{data: res_data_in, num: res_num_in,
                         wr: res_valid_in & res_write_in & ~flush_in};
            for (int k = 1; k < DEPTH; k++) begin
                hist[k+1] <= hist[k];
                if (flush_in && k <= FLUSH_SLOTS) hist[k+1].wr <= 1'b0;
            end
            if (retire_wr) retire_count_out <= retire_count_out + 16'd1;
        end
    end

    kl_regfile u_regfile (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (retire_wr),
        .wr_num    (hist[DEPTH].num),
        .wr_data   (hist[DEPTH].data),
        .rd_a_num  (rd_a_num_in),
        .rd_a_data (rd_a_data_out),
        .rd_b_num  (rd_b_num_in),
        .rd_b_data (rd_b_data_out)
    );

    assign data_m1_out  = hist[1].data;
    assign data_m2_out  = hist[2].data;
    assign data_m3_out  = hist[3].data;
    assign data_m4_out  = hist[4].data;
    assign data_m5_out  = hist[5].data;
    assign data_m6_out  = hist[6].data;
    assign num_m1_out   = hist[1].num;
    assign num_m2_out   = hist[2].num;
    assign num_m3_out   = hist[3].num;
    assign num_m4_out   = hist[4].num;
    assign num_m5_out   = hist[5].num;
    assign num_m6_out   = hist[6].num;
    assign m1_write_out = hist[1].wr;
    assign m2_write_out = hist[2].wr;
    assign m3_write_out = hist[3].wr;
    assign m4_write_out = hist[4].wr;
    assign m5_write_out = hist[5].wr;
    assign m6_write_out = hist[6].wr;

endmodule
